// File: rtl/l1_eviction_buffer_pkg.sv
// ---------------------------------------------------------------------------
// l1_eviction_buffer_pkg
//   Shared types for the L1 eviction (write-back) buffer.
//   Contents:
//     lc3b_word       16-bit LC-3b address/word
//     lc3b_cacheline  128-bit cache line
//     lc3b_line_tag   line address bits [15:4]
//     lc3b_ewb_state  buffer controller states (IDLE, RD_L2, WR_L2, RESP)
//     line_base()     expands a line tag to a line-aligned byte address
// ---------------------------------------------------------------------------
package l1_eviction_buffer_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef logic [11:0]  lc3b_line_tag;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_L2 = 2'd1,
    WR_L2 = 2'd2,
    RESP  = 2'd3
  } lc3b_ewb_state;

  localparam int LINE_OFFSET_BITS = 4;

  // Line-aligned address: the byte offset within the line is always zero.
  function automatic lc3b_word line_base(input lc3b_line_tag tag);
    return {tag, {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l1_ewb_storage.sv
// ---------------------------------------------------------------------------
// l1_ewb_storage
//   Entry storage for the eviction buffer: DEPTH x {valid, tag, data}, with a
//   fully associative tag lookup and a head-entry read port.
//   Ports:
//     clk, rst_n              clock / asynchronous active-low reset (clears valids)
//     wr_en, wr_idx           write (allocate or overwrite) entry wr_idx
//     wr_tag, wr_data         tag and line written
//     inv_en, inv_idx         invalidate entry inv_idx (drain completed)
//     lookup_tag              tag compared against every valid entry
//     match_any, match_idx    hit flag and encoded index of the matching entry
//     match_data              line stored in the matching entry
//     head_idx                entry to read for draining
//     head_tag, head_data     tag and line of entry head_idx
// ---------------------------------------------------------------------------
module l1_ewb_storage
  import l1_eviction_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_idx,
  input  lc3b_line_tag       wr_tag,
  input  lc3b_cacheline      wr_data,
  input  logic               inv_en,
  input  logic [PTR_W-1:0]   inv_idx,
  input  lc3b_line_tag       lookup_tag,
  output logic               match_any,
  output logic [PTR_W-1:0]   match_idx,
  output lc3b_cacheline      match_data,
  input  logic [PTR_W-1:0]   head_idx,
  output lc3b_line_tag       head_tag,
  output lc3b_cacheline      head_data
);

  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] match_vec;
  lc3b_line_tag     tag_arr  [DEPTH];
  lc3b_cacheline    data_arr [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic          entry_valid_reg;
      lc3b_line_tag  entry_tag_reg;
      lc3b_cacheline entry_data_reg;

      // Allocation and drain never target the same entry in one cycle, so
      // the write/invalidate ordering below only matters for robustness.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_valid_reg <= 1'b0;
        end else if (wr_en && (wr_idx == PTR_W'(gi))) begin
          entry_valid_reg <= 1'b1;
        end else if (inv_en && (inv_idx == PTR_W'(gi))) begin
          entry_valid_reg <= 1'b0;
        end
      end

      // Tag/data need no reset: they are qualified by the valid bit.
      always_ff @(posedge clk) begin
        if (wr_en && (wr_idx == PTR_W'(gi))) begin
          entry_tag_reg  <= wr_tag;
          entry_data_reg <= wr_data;
        end
      end

      assign valid_vec[gi] = entry_valid_reg;
      assign tag_arr[gi]   = entry_tag_reg;
      assign data_arr[gi]  = entry_data_reg;
      assign match_vec[gi] = entry_valid_reg && (entry_tag_reg == lookup_tag);
    end
  endgenerate

  // At most one entry can hold a given tag (writes to a buffered line
  // overwrite in place), so an OR-reduction encoder is sufficient.
  always_comb begin
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_vec[i]) begin
        match_idx = match_idx | PTR_W'(i);
      end
    end
  end

  assign match_any  = |match_vec;
  assign match_data = data_arr[match_idx];
  assign head_tag   = tag_arr[head_idx];
  assign head_data  = data_arr[head_idx];

`ifndef SYNTHESIS
  a_one_hot_match: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(match_vec));
  a_match_valid:   assert property (@(posedge clk) disable iff (!rst_n) (match_vec & ~valid_vec) == '0);
`endif

endmodule

// File: rtl/l1_eviction_buffer.sv
// ---------------------------------------------------------------------------
// l1_eviction_buffer
//   Write-back buffer between the L1 memory-side port and L2. Dirty-line
//   evictions are absorbed without touching L2, so the refill read that
//   follows an eviction reaches L2 first. Buffered lines drain to L2 in FIFO
//   order whenever no L1 request is pending.
//   Build option:
//     L1_EWB_FWD_EN  defined: a read hitting a buffered line is served from
//                    the buffer. Undefined: entries are drained up to and
//                    including the hit, then the line is read from L2.
//   Ports:
//     clk, rst_n                 clock / asynchronous active-low reset
//     l1_read, l1_write          L1 request (held until l1_resp)
//     l1_address, l1_wdata       L1 line address (bits [3:0] ignored), eviction data
//     l1_resp, l1_rdata          one-cycle completion pulse, read data
//     l2_read, l2_write          L2 request (held until l2_resp)
//     l2_address, l2_wdata       L2 line address (bits [3:0] zero), drain data
//     l2_resp, l2_rdata          L2 completion, L2 read data
// ---------------------------------------------------------------------------
module l1_eviction_buffer
  import l1_eviction_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          l1_read,
  input  logic          l1_write,
  input  lc3b_word      l1_address,
  input  lc3b_cacheline l1_wdata,
  output logic          l1_resp,
  output lc3b_cacheline l1_rdata,
  output logic          l2_read,
  output logic          l2_write,
  output lc3b_word      l2_address,
  output lc3b_cacheline l2_wdata,
  input  logic          l2_resp,
  input  lc3b_cacheline l2_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  lc3b_ewb_state    state_reg, state_next;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic             l1_resp_reg, l1_resp_next;
  lc3b_cacheline    l1_rdata_reg, l1_rdata_next;
  logic             l2_read_reg, l2_read_next;
  logic             l2_write_reg, l2_write_next;
  lc3b_word         l2_address_reg, l2_address_next;
  lc3b_cacheline    l2_wdata_reg, l2_wdata_next;

  logic             st_wr_en;
  logic [PTR_W-1:0] st_wr_idx;
  logic             st_inv_en;
  logic             match_any;
  logic [PTR_W-1:0] match_idx;
  lc3b_cacheline    fwd_data;
  lc3b_line_tag     head_tag;
  lc3b_cacheline    head_data;
  lc3b_line_tag     req_tag;
  logic             full;
  logic             start_drain;
  logic             start_read;
  logic             enq_en;

  assign req_tag = l1_address[15:4];
  assign full    = (count_reg == CNT_W'(DEPTH));

  logic unused_addr_bits;
  assign unused_addr_bits = ^l1_address[3:0];
`ifndef L1_EWB_FWD_EN
  logic unused_fwd_data;
  assign unused_fwd_data = ^fwd_data;
`endif

  l1_ewb_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (st_wr_en),
    .wr_idx     (st_wr_idx),
    .wr_tag     (req_tag),
    .wr_data    (l1_wdata),
    .inv_en     (st_inv_en),
    .inv_idx    (head_reg),
    .lookup_tag (req_tag),
    .match_any  (match_any),
    .match_idx  (match_idx),
    .match_data (fwd_data),
    .head_idx   (head_reg),
    .head_tag   (head_tag),
    .head_data  (head_data)
  );

  always_comb begin
    state_next      = state_reg;
    head_next       = head_reg;
    tail_next       = tail_reg;
    count_next      = count_reg;
    l1_resp_next    = 1'b0;
    l1_rdata_next   = l1_rdata_reg;
    l2_read_next    = l2_read_reg;
    l2_write_next   = l2_write_reg;
    l2_address_next = l2_address_reg;
    l2_wdata_next   = l2_wdata_reg;
    st_wr_en        = 1'b0;
    st_wr_idx       = tail_reg;
    st_inv_en       = 1'b0;
    start_drain     = 1'b0;
    start_read      = 1'b0;
    enq_en          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (l1_write && full && !match_any) begin
          // Make room first; the eviction is accepted on return to IDLE.
          start_drain = 1'b1;
        end else if (l1_write) begin
          st_wr_en = 1'b1;
          if (match_any) begin
            st_wr_idx = match_idx;
          end else begin
            enq_en     = 1'b1;
            tail_next  = ptr_inc(tail_reg);
            count_next = count_reg + CNT_W'(1);
          end
          state_next   = RESP;
          l1_resp_next = 1'b1;
        end else if (l1_read && match_any) begin
`ifdef L1_EWB_FWD_EN
          l1_rdata_next = fwd_data;
          state_next    = RESP;
          l1_resp_next  = 1'b1;
`else
          // L2 holds stale data for this line: flush in order up to it.
          start_drain = 1'b1;
`endif
        end else if (l1_read) begin
          start_read = 1'b1;
        end else if (count_reg != '0) begin
          start_drain = 1'b1;
        end
      end

      RD_L2: begin
        if (l2_resp) begin
          l1_rdata_next = l2_rdata;
          l2_read_next  = 1'b0;
          state_next    = RESP;
          l1_resp_next  = 1'b1;
        end
      end

      WR_L2: begin
        if (l2_resp) begin
          st_inv_en     = 1'b1;
          head_next     = ptr_inc(head_reg);
          count_next    = count_reg - CNT_W'(1);
          l2_write_next = 1'b0;
          // The waiting read's line just reached L2: fetch it directly.
          if (l1_read && match_any && (match_idx == head_reg)) begin
            start_read = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (start_drain) begin
      state_next      = WR_L2;
      l2_write_next   = 1'b1;
      l2_address_next = line_base(head_tag);
      l2_wdata_next   = head_data;
    end
    if (start_read) begin
      state_next      = RD_L2;
      l2_read_next    = 1'b1;
      l2_address_next = line_base(req_tag);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      l1_resp_reg    <= 1'b0;
      l1_rdata_reg   <= '0;
      l2_read_reg    <= 1'b0;
      l2_write_reg   <= 1'b0;
      l2_address_reg <= '0;
      l2_wdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      count_reg      <= count_next;
      l1_resp_reg    <= l1_resp_next;
      l1_rdata_reg   <= l1_rdata_next;
      l2_read_reg    <= l2_read_next;
      l2_write_reg   <= l2_write_next;
      l2_address_reg <= l2_address_next;
      l2_wdata_reg   <= l2_wdata_next;
    end
  end

  assign l1_resp    = l1_resp_reg;
  assign l1_rdata   = l1_rdata_reg;
  assign l2_read    = l2_read_reg;
  assign l2_write   = l2_write_reg;
  assign l2_address = l2_address_reg;
  assign l2_wdata   = l2_wdata_reg;

`ifndef SYNTHESIS
  a_count_bound:  assert property (@(posedge clk) disable iff (!rst_n) count_reg <= CNT_W'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) st_inv_en |-> (count_reg != '0));
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) enq_en |-> !full);
  a_enq_xor_deq:  assert property (@(posedge clk) disable iff (!rst_n) !(enq_en && st_inv_en));
  a_l2_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(l2_read_reg && l2_write_reg));
`endif

endmodule

// File: tb/tb_l1_eviction_buffer.sv
`timescale 1ns/1ps
module tb_l1_eviction_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         l1_read = 1'b0;
  logic         l1_write = 1'b0;
  logic [15:0]  l1_address = '0;
  logic [127:0] l1_wdata = '0;
  logic         l1_resp;
  logic [127:0] l1_rdata;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic         l2_resp;
  logic [127:0] l2_rdata;

  l1_eviction_buffer #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .l1_read    (l1_read),
    .l1_write   (l1_write),
    .l1_address (l1_address),
    .l1_wdata   (l1_wdata),
    .l1_resp    (l1_resp),
    .l1_rdata   (l1_rdata),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_resp    (l2_resp),
    .l2_rdata   (l2_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int l2_lat = 1;

  typedef struct {
    bit           is_read;
    logic [127:0] data;
    int           cyc;
  } l1_exp_t;

  typedef struct {
    bit           is_write;
    logic [15:0]  addr;
    logic [127:0] data;
    int           cyc;
  } l2_exp_t;

  l1_exp_t l1_q[$];
  l2_exp_t l2_q[$];

  logic [127:0] l2_mem [logic [11:0]];

  function automatic logic [127:0] rd_pat(input logic [15:0] a);
    return {4{a, ~a}};
  endfunction

  function automatic logic [127:0] dpat(input logic [15:0] s);
    return {8{s}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- L2 memory model ----------------
  initial begin
    int wcnt;
    wcnt = 0;
    l2_resp = 1'b0;
    l2_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        l2_resp = 1'b0;
        wcnt = 0;
      end else if (l2_resp) begin
        l2_resp = 1'b0;
        wcnt = 0;
      end else if (l2_read || l2_write) begin
        if (wcnt >= l2_lat - 1) begin
          l2_resp = 1'b1;
          if (l2_write) l2_mem[l2_address[15:4]] = l2_wdata;
          else l2_rdata = l2_mem.exists(l2_address[15:4]) ? l2_mem[l2_address[15:4]] : rd_pat(l2_address);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit prev_active, prev_done, active;
    l1_exp_t e1;
    l2_exp_t e2;
    prev_active = 0;
    prev_done = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_active = 0;
        prev_done = 0;
      end else begin
        if (l1_resp) begin
          if (l1_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL l1_unexpected: got l1_resp at cycle %0d required none", cyc);
          end else begin
            e1 = l1_q.pop_front();
            $display("l1 resp cyc=%0d read=%0b rdata=%h", cyc, e1.is_read, l1_rdata);
            if (e1.cyc >= 0) chk("l1_resp_cycle", 128'(cyc), 128'(e1.cyc));
            if (e1.is_read) chk("l1_rdata", l1_rdata, e1.data);
          end
        end
        active = l2_read || l2_write;
        if (active && (!prev_active || prev_done)) begin
          $display("l2 txn cyc=%0d rd=%0b wr=%0b addr=%h data=%h", cyc, l2_read, l2_write, l2_address, l2_wdata);
          chk("l2_rd_wr_both", 128'(l2_read && l2_write), 128'(0));
          if (l2_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL l2_unexpected: got txn addr %h at cycle %0d required none", l2_address, cyc);
          end else begin
            e2 = l2_q.pop_front();
            chk("l2_kind_write", 128'(l2_write), 128'(e2.is_write));
            chk("l2_address", 128'(l2_address), 128'(e2.addr));
            if (e2.is_write) chk("l2_wdata", l2_wdata, e2.data);
            if (e2.cyc >= 0) chk("l2_start_cycle", 128'(cyc), 128'(e2.cyc));
          end
        end
        prev_active = active;
        prev_done = active && l2_resp;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the edge that
  // follows the sampled l1_resp, with the request dropped.
  task automatic l1_req(input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                        input logic [127:0] exp_rd, input int lat, input string name);
    bit seen;
    l1_q.push_back('{is_read: !wr, data: exp_rd, cyc: (lat < 0) ? -1 : cyc + lat});
    l1_write = wr;
    l1_read = !wr;
    l1_address = addr;
    l1_wdata = wd;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (l1_resp) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no l1_resp in 200 cycles required one", name);
    end
    @(posedge clk);
    #1;
    l1_read = 1'b0;
    l1_write = 1'b0;
  endtask

  task automatic l2_exp(input bit wr, input logic [15:0] addr, input logic [127:0] d, input int c);
    l2_q.push_back('{is_write: wr, addr: addr, data: d, cyc: c});
  endtask

  task automatic wait_idle(input string name);
    int quiet;
    quiet = 0;
    for (int i = 0; i < 400 && quiet < 4; i++) begin
      @(negedge clk);
      #1;
      if (!l2_read && !l2_write && l2_q.size() == 0) quiet++;
      else quiet = 0;
    end
    chk({name, "_l2_pending"}, 128'(l2_q.size()), 128'(0));
    chk({name, "_l1_pending"}, 128'(l1_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_l1_resp"}, 128'(l1_resp), 128'(0));
    chk({name, "_l1_rdata"}, l1_rdata, 128'(0));
    chk({name, "_l2_read"}, 128'(l2_read), 128'(0));
    chk({name, "_l2_write"}, 128'(l2_write), 128'(0));
    chk({name, "_l2_address"}, 128'(l2_address), 128'(0));
    chk({name, "_l2_wdata"}, l2_wdata, 128'(0));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int any_act;
    bit seen;

    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single eviction, buffered silently, drained when idle
    l2_lat = 1;
    l2_exp(1'b1, 16'h1230, dpat(16'h1230), cyc + 3);
    l1_req(1'b1, 16'h1230, dpat(16'h1230), '0, 1, "t1_wr");
    wait_idle("t1");

    // 2: third write into a full buffer waits for the head to drain
    l2_lat = 4;
    l2_exp(1'b1, 16'h1000, dpat(16'h1000), cyc + 5);
    l2_exp(1'b1, 16'h2000, dpat(16'h2000), -1);
    l2_exp(1'b1, 16'h3000, dpat(16'h3000), -1);
    l1_req(1'b1, 16'h1000, dpat(16'h1000), '0, 1, "t2_wr1");
    l1_req(1'b1, 16'h2000, dpat(16'h2000), '0, 1, "t2_wr2");
    l1_req(1'b1, 16'h3000, dpat(16'h3000), '0, 6, "t2_wr3");
    wait_idle("t2");

    // 3: refill read overtakes the buffered eviction
    l2_lat = 2;
    l2_exp(1'b0, 16'h5000, '0, cyc + 3);
    l2_exp(1'b1, 16'h4000, dpat(16'h4000), -1);
    l1_req(1'b1, 16'h4000, dpat(16'h4000), '0, 1, "t3_wr");
    l1_req(1'b0, 16'h5000, '0, rd_pat(16'h5000), 3, "t3_rd");
    wait_idle("t3");

    // 4: second write to the same line overwrites in place
    l2_lat = 1;
    l2_exp(1'b1, 16'h6000, dpat(16'hD2D2), -1);
    l1_req(1'b1, 16'h6000, dpat(16'hD1D1), '0, 1, "t4_wr1");
    l1_req(1'b1, 16'h6008, dpat(16'hD2D2), '0, 1, "t4_wr2");
    wait_idle("t4");

    // 5: read of a buffered line never returns stale L2 data
    l2_lat = 1;
`ifdef L1_EWB_FWD_EN
    l2_exp(1'b1, 16'h7000, dpat(16'hD3D3), -1);
    l1_req(1'b1, 16'h7000, dpat(16'hD3D3), '0, 1, "t5_wr");
    l1_req(1'b0, 16'h7000, '0, dpat(16'hD3D3), 1, "t5_rd");
`else
    l2_exp(1'b1, 16'h7000, dpat(16'hD3D3), cyc + 3);
    l2_exp(1'b0, 16'h7000, '0, -1);
    l1_req(1'b1, 16'h7000, dpat(16'hD3D3), '0, 1, "t5_wr");
    l1_req(1'b0, 16'h7000, '0, dpat(16'hD3D3), -1, "t5_rd");
`endif
    wait_idle("t5");

    // 6: reset in the middle of a drain
    l2_lat = 8;
    l2_exp(1'b1, 16'h8000, dpat(16'h8000), -1);
    l1_req(1'b1, 16'h8000, dpat(16'h8000), '0, 1, "t6_wr");
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (l2_write) seen = 1;
    end
    chk("t6_drain_started", 128'(seen), 128'(1));
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("t6_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (l2_read || l2_write || l1_resp) any_act++;
    end
    chk("t6_quiet_after_reset", 128'(any_act), 128'(0));
    @(posedge clk);
    #1;
    l2_lat = 1;
    l2_exp(1'b0, 16'h8000, '0, cyc + 1);
    l1_req(1'b0, 16'h8000, '0, rd_pat(16'h8000), 2, "t6_rd");
    wait_idle("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
